// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side signals of the two-client RAM port arbiter.
// slave = arbiter view, master = clients plus RAM instance view.
interface ram_port_arbiter_if #(
   parameter int DW = 16,
   parameter int AW = 3
);
   logic          a_req;
   logic          a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_din;
   logic          a_gnt;
   logic          a_rvalid;
   logic [DW-1:0] a_rdata;

   logic          b_req;
   logic          b_we;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_din;
   logic          b_gnt;
   logic          b_rvalid;
   logic [DW-1:0] b_rdata;

   logic          ram_we;
   logic [AW-1:0] ram_wr_addr;
   logic [DW-1:0] ram_din;
   logic          ram_re;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_dout;

   modport slave (
      input  a_req, a_we, a_addr, a_din,
      input  b_req, b_we, b_addr, b_din,
      input  ram_dout,
      output a_gnt, a_rvalid, a_rdata,
      output b_gnt, b_rvalid, b_rdata,
      output ram_we, ram_wr_addr, ram_din, ram_re, ram_rd_addr
   );

   modport master (
      output a_req, a_we, a_addr, a_din,
      output b_req, b_we, b_addr, b_din,
      output ram_dout,
      input  a_gnt, a_rvalid, a_rdata,
      input  b_gnt, b_rvalid, b_rdata,
      input  ram_we, ram_wr_addr, ram_din, ram_re, ram_rd_addr
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one two-port RAM between requesters A and B: independent round-robin
// arbitration of the write and read ports, RAW hold-off, read-return steering.

module ram_port_arbiter_lane #(
   parameter int DW = 16,
   parameter int ID = 0
) (
   input  logic          req_i,
   input  logic          we_i,
   input  logic          wr_gnt_i,
   input  logic          wr_sel_i,
   input  logic          rd_gnt_i,
   input  logic          rd_sel_i,
   input  logic          rd_pend_i,
   input  logic          rd_owner_i,
   input  logic [DW-1:0] ram_dout_i,
   output logic          wr_cand_o,
   output logic          rd_cand_o,
   output logic          gnt_o,
   output logic          rvalid_o,
   output logic [DW-1:0] rdata_o
);
   localparam logic MY_ID = 1'(ID);

   assign wr_cand_o = req_i & we_i;
   assign rd_cand_o = req_i & ~we_i;
   assign gnt_o     = (wr_gnt_i & (wr_sel_i == MY_ID)) | (rd_gnt_i & (rd_sel_i == MY_ID));

   // RAM dout is only trustworthy in the cycle after a read we issued
   assign rvalid_o  = rd_pend_i & (rd_owner_i == MY_ID);
   assign rdata_o   = rvalid_o ? ram_dout_i : '0;
endmodule

module ram_port_arbiter #(
   parameter int DW = 16,
   parameter int AW = 3
) (
   input  logic             clk,
   input  logic             rst,
   ram_port_arbiter_if.slave port_io
);
   localparam int NUM_REQ = 2;

   typedef struct packed {
      logic          req;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
   } cmd_t;

   cmd_t [NUM_REQ-1:0]          cmd;
   logic [NUM_REQ-1:0]          wr_cand;
   logic [NUM_REQ-1:0]          rd_cand;
   logic [NUM_REQ-1:0]          gnt;
   logic [NUM_REQ-1:0]          rvalid;
   logic [NUM_REQ-1:0][DW-1:0]  rdata;

   logic wr_prio_q, wr_prio_d;
   logic rd_prio_q, rd_prio_d;
   logic rd_pend_q, rd_pend_d;
   logic rd_owner_q, rd_owner_d;

   logic wr_any, rd_any, wr_sel, rd_sel;
   logic hazard, wr_gnt, rd_gnt;

   assign cmd[0] = {port_io.a_req, port_io.a_we, port_io.a_addr, port_io.a_din};
   assign cmd[1] = {port_io.b_req, port_io.b_we, port_io.b_addr, port_io.b_din};

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      ram_port_arbiter_lane #(.DW(DW), .ID(i)) u_lane (
         .req_i      (cmd[i].req),
         .we_i       (cmd[i].we),
         .wr_gnt_i   (wr_gnt),
         .wr_sel_i   (wr_sel),
         .rd_gnt_i   (rd_gnt),
         .rd_sel_i   (rd_sel),
         .rd_pend_i  (rd_pend_q),
         .rd_owner_i (rd_owner_q),
         .ram_dout_i (port_io.ram_dout),
         .wr_cand_o  (wr_cand[i]),
         .rd_cand_o  (rd_cand[i]),
         .gnt_o      (gnt[i]),
         .rvalid_o   (rvalid[i]),
         .rdata_o    (rdata[i])
      );
   end

   // A lone candidate wins outright; the pointer only breaks ties
   always_comb begin
      wr_any = |wr_cand;
      rd_any = |rd_cand;
      wr_sel = (&wr_cand) ? wr_prio_q : wr_cand[1];
      rd_sel = (&rd_cand) ? rd_prio_q : rd_cand[1];
      hazard = wr_any & rd_any & (cmd[wr_sel].addr == cmd[rd_sel].addr);
      wr_gnt = wr_any & ~rst;
      // A same-address read waits one cycle so it returns the new data
      rd_gnt = rd_any & ~hazard & ~rst;
   end

   always_comb begin
      wr_prio_d  = wr_gnt ? ~wr_sel : wr_prio_q;
      rd_prio_d  = rd_gnt ? ~rd_sel : rd_prio_q;
      rd_pend_d  = rd_gnt;
      rd_owner_d = rd_gnt ? rd_sel : rd_owner_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_prio_q  <= 1'b0;
         rd_prio_q  <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
      end else begin
         wr_prio_q  <= wr_prio_d;
         rd_prio_q  <= rd_prio_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   always_comb begin
      port_io.ram_we      = wr_gnt;
      port_io.ram_wr_addr = wr_gnt ? cmd[wr_sel].addr : '0;
      port_io.ram_din     = wr_gnt ? cmd[wr_sel].din  : '0;
      port_io.ram_re      = rd_gnt;
      port_io.ram_rd_addr = rd_gnt ? cmd[rd_sel].addr : '0;
   end

   assign port_io.a_gnt    = gnt[0];
   assign port_io.b_gnt    = gnt[1];
   assign port_io.a_rvalid = rvalid[0];
   assign port_io.b_rvalid = rvalid[1];
   assign port_io.a_rdata  = rdata[0];
   assign port_io.b_rdata  = rdata[1];

   a_no_raw_collision: assert property (@(posedge clk)
      !(port_io.ram_we && port_io.ram_re && (port_io.ram_wr_addr == port_io.ram_rd_addr)));
endmodule
